// File: rtl/axi_lite_master_bridge.sv
// AXI4-Lite initiator bridge.
// It converts single-beat core requests into AXI4-Lite read or write transactions.
// Only one transaction is outstanding at a time.
// Every AXI VALID/READY output and every core handshake output comes straight from a flop.
module axi_lite_master_bridge #(
  parameter int unsigned AWIDTH = 32,
  parameter int unsigned DWIDTH = 64,
  parameter int unsigned DSIZE  = DWIDTH / 8
) (
  input  logic              clk,
  input  logic              resetn,
  // core request
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wen,
  input  logic [AWIDTH-1:0] req_addr,
  input  logic [DWIDTH-1:0] req_wdata,
  input  logic [DSIZE-1:0]  req_wstrb,
  // core response
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DWIDTH-1:0] resp_rdata,
  output logic              resp_err,
  // AXI write address
  output logic [AWIDTH-1:0] AWADDR,
  output logic              AWVALID,
  input  logic              AWREADY,
  // AXI write data
  output logic [DWIDTH-1:0] WDATA,
  output logic [DSIZE-1:0]  WSTRB,
  output logic              WVALID,
  input  logic              WREADY,
  // AXI write response
  input  logic [1:0]        BRESP,
  input  logic              BVALID,
  output logic              BREADY,
  // AXI read address
  output logic [AWIDTH-1:0] ARADDR,
  output logic              ARVALID,
  input  logic              ARREADY,
  // AXI read data
  input  logic [DWIDTH-1:0] RDATA,
  input  logic [1:0]        RRESP,
  input  logic              RVALID,
  output logic              RREADY
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_AR   = 3'd1,
    S_R    = 3'd2,
    S_AW_W = 3'd3,
    S_B    = 3'd4,
    S_RESP = 3'd5
  } state_t;

  state_t              state_q, state_n;
  logic [AWIDTH-1:0]   addr_q, addr_n;
  logic [DWIDTH-1:0]   wdata_q, wdata_n;
  logic [DSIZE-1:0]    wstrb_q, wstrb_n;
  logic [DWIDTH-1:0]   rdata_q, rdata_n;
  logic                err_q, err_n;
  logic                aw_done_q, aw_done_n;
  logic                w_done_q, w_done_n;
  logic                awvalid_q, awvalid_n;
  logic                wvalid_q, wvalid_n;
  logic                arvalid_q, arvalid_n;
  logic                rready_q, rready_n;
  logic                bready_q, bready_n;
  logic                req_ready_q, req_ready_n;
  logic                resp_valid_q, resp_valid_n;
  logic                aw_hs, w_hs;

  // State and registered outputs; reset abandons any in-flight transaction.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
      aw_done_q    <= 1'b0;
      w_done_q     <= 1'b0;
      awvalid_q    <= 1'b0;
      wvalid_q     <= 1'b0;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      bready_q     <= 1'b0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
    end else begin
      state_q      <= state_n;
      addr_q       <= addr_n;
      wdata_q      <= wdata_n;
      wstrb_q      <= wstrb_n;
      rdata_q      <= rdata_n;
      err_q        <= err_n;
      aw_done_q    <= aw_done_n;
      w_done_q     <= w_done_n;
      awvalid_q    <= awvalid_n;
      wvalid_q     <= wvalid_n;
      arvalid_q    <= arvalid_n;
      rready_q     <= rready_n;
      bready_q     <= bready_n;
      req_ready_q  <= req_ready_n;
      resp_valid_q <= resp_valid_n;
    end
  end

  // Next-state, payload capture and next values of the registered handshake outputs.
  always_comb begin
    state_n   = state_q;
    addr_n    = addr_q;
    wdata_n   = wdata_q;
    wstrb_n   = wstrb_q;
    rdata_n   = rdata_q;
    err_n     = err_q;
    aw_done_n = 1'b0;
    w_done_n  = 1'b0;
    awvalid_n = 1'b0;
    wvalid_n  = 1'b0;
    aw_hs     = awvalid_q & AWREADY;
    w_hs      = wvalid_q & WREADY;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          addr_n = req_addr;
          if (req_wen) begin
            wdata_n   = req_wdata;
            wstrb_n   = req_wstrb;
            awvalid_n = 1'b1;
            wvalid_n  = 1'b1;
            state_n   = S_AW_W;
          end else begin
            state_n = S_AR;
          end
        end
      end
      S_AR: begin
        if (arvalid_q && ARREADY) state_n = S_R;
      end
      S_R: begin
        if (rready_q && RVALID) begin
          rdata_n = RDATA;
          err_n   = (RRESP != 2'b00);
          state_n = S_RESP;
        end
      end
      S_AW_W: begin
        // Each channel retires on its own handshake.
        // The state moves on once both channels are done.
        aw_done_n = aw_done_q | aw_hs;
        w_done_n  = w_done_q | w_hs;
        awvalid_n = awvalid_q & ~AWREADY;
        wvalid_n  = wvalid_q & ~WREADY;
        if (aw_done_n && w_done_n) state_n = S_B;
      end
      S_B: begin
        if (bready_q && BVALID) begin
          err_n   = (BRESP != 2'b00);
          state_n = S_RESP;
        end
      end
      S_RESP: begin
        if (resp_ready) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase

    arvalid_n    = (state_n == S_AR);
    rready_n     = (state_n == S_R);
    bready_n     = (state_n == S_B);
    req_ready_n  = (state_n == S_IDLE);
    resp_valid_n = (state_n == S_RESP);
  end

  // Output drive from registers.
  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  assign AWADDR     = addr_q;
  assign AWVALID    = awvalid_q;
  assign WDATA      = wdata_q;
  assign WSTRB      = wstrb_q;
  assign WVALID     = wvalid_q;
  assign BREADY     = bready_q;
  assign ARADDR     = addr_q;
  assign ARVALID    = arvalid_q;
  assign RREADY     = rready_q;

endmodule

// File: tb/tb_axi_lite_master_bridge.sv
// Randomized bench for axi_lite_master_bridge.
// It checks the bridge against a cycle-count model of each transaction.
module tb_axi_lite_master_bridge;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 64;
  localparam int unsigned DS = 8;
  localparam logic [6:0] IDLE_CTL = 7'b1000000;

  logic          clk = 1'b0;
  logic          resetn;
  logic          req_valid, req_ready, req_wen;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [DS-1:0] req_wstrb;
  logic          resp_valid, resp_ready, resp_err;
  logic [DW-1:0] resp_rdata;
  logic [AW-1:0] AWADDR, ARADDR;
  logic          AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
  logic          ARVALID, ARREADY, RVALID, RREADY;
  logic [DW-1:0] WDATA, RDATA;
  logic [DS-1:0] WSTRB;
  logic [1:0]    BRESP, RRESP;

  int unsigned   n_checks = 0;
  int unsigned   n_pass = 0;
  logic [DW-1:0] last_rdata;
  logic          last_err;

  axi_lite_master_bridge #(.AWIDTH(AW), .DWIDTH(DW), .DSIZE(DS)) dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [6:0] ctl_obs();
    return {req_ready, resp_valid, ARVALID, RREADY, AWVALID, WVALID, BREADY};
  endfunction

  task automatic axi_idle();
    ARREADY = 1'b0; RVALID = 1'b0; RDATA = '0; RRESP = 2'b00;
    AWREADY = 1'b0; WREADY = 1'b0; BVALID = 1'b0; BRESP = 2'b00;
    resp_ready = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ctl"}, 64'(ctl_obs()), 64'(IDLE_CTL));
    chk({tag, "_addr"}, 64'({AWADDR, ARADDR}), 64'd0);
    chk({tag, "_wdata"}, 64'(WDATA), 64'd0);
    chk({tag, "_wstrb"}, 64'(WSTRB), 64'd0);
    chk({tag, "_rdata"}, 64'(resp_rdata), 64'd0);
    chk({tag, "_err"}, 64'(resp_err), 64'd0);
  endtask

  // One transaction, entered and left at a negedge while the bridge is idle.
  // Waits are counted in slave stall cycles: a (AR or AW), w (W), b2 (R or B), rr (resp_ready).
  task automatic run_tx(input logic wen, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                        input logic [DS-1:0] wstrb, input logic [DW-1:0] rdata, input logic [1:0] resp,
                        input int a, input int w, input int b2, input int rr);
    int d, rs;
    logic done, r_done, b_done;
    logic [6:0] exp;
    d  = 1 + ((a > w) ? a : w);
    rs = wen ? (d + 2 + b2) : (3 + a + b2);
    chk("idle_ctl", 64'(ctl_obs()), 64'(IDLE_CTL));
    req_valid = 1'b1; req_wen = wen; req_addr = addr; req_wdata = wdata; req_wstrb = wstrb;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    req_wen   = 1'($urandom);
    req_addr  = $urandom;
    req_wdata = {$urandom, $urandom};
    req_wstrb = DS'($urandom);
    done = 1'b0; r_done = 1'b0; b_done = 1'b0;
    for (int c = 1; c < 100 && !done; c++) begin
      exp = 7'b0;
      exp[5] = (c >= rs);
      if (!wen) begin
        exp[4] = (c <= 1 + a);
        exp[3] = (c >= 2 + a) && (c <= 2 + a + b2);
      end else begin
        exp[2] = (c <= 1 + a);
        exp[1] = (c <= 1 + w);
        exp[0] = (c >= d + 1) && (c <= d + 1 + b2);
      end
      chk("ctl", 64'(ctl_obs()), 64'(exp));
      if (exp[4]) chk("araddr", 64'(ARADDR), 64'(addr));
      if (exp[2]) chk("awaddr", 64'(AWADDR), 64'(addr));
      if (exp[1]) begin
        chk("wdata", 64'(WDATA), 64'(wdata));
        chk("wstrb", 64'(WSTRB), 64'(wstrb));
      end
      if (exp[5]) begin
        chk("rdata", 64'(resp_rdata), wen ? 64'(last_rdata) : 64'(rdata));
        chk("err", 64'(resp_err), 64'(resp != 2'b00));
      end
      if (!wen) begin
        ARREADY = (c >= 1 + a);
        RVALID  = (c >= 2 + a + b2) && !r_done;
        RDATA   = RVALID ? rdata : {$urandom, $urandom};
        RRESP   = RVALID ? resp : 2'($urandom);
        AWREADY = 1'($urandom); WREADY = 1'($urandom);
        BVALID  = 1'($urandom); BRESP = 2'($urandom);
      end else begin
        AWREADY = (c >= 1 + a);
        WREADY  = (c >= 1 + w);
        BVALID  = (c >= d + 1 + b2) && !b_done;
        BRESP   = BVALID ? resp : 2'($urandom);
        ARREADY = 1'($urandom);
        RVALID  = 1'($urandom); RDATA = {$urandom, $urandom}; RRESP = 2'($urandom);
      end
      resp_ready = (c >= rs + rr);
      if (!wen && RVALID && RREADY) r_done = 1'b1;
      if (wen && BVALID && BREADY) b_done = 1'b1;
      if (resp_valid && resp_ready) done = 1'b1;
      @(negedge clk);
    end
    if (!done) chk("timeout", 64'd0, 64'd1);
    axi_idle();
    if (!wen) last_rdata = rdata;
    last_err = (resp != 2'b00);
  endtask

  // Response-channel noise while idle must not be taken up.
  task automatic spurious(input int n);
    for (int i = 0; i < n; i++) begin
      RVALID = 1'b1; BVALID = 1'b1; RRESP = 2'b11; BRESP = 2'b10; RDATA = {$urandom, $urandom};
      @(negedge clk);
      chk("spur_ctl", 64'(ctl_obs()), 64'(IDLE_CTL));
      chk("spur_err", 64'(resp_err), 64'(last_err));
      chk("spur_rdata", 64'(resp_rdata), 64'(last_rdata));
    end
    axi_idle();
  endtask

  // Reset asserted while ARVALID waits on a stalled ARREADY.
  task automatic reset_mid();
    logic [AW-1:0] addr;
    addr = $urandom;
    chk("rst_pre_idle", 64'(ctl_obs()), 64'(IDLE_CTL));
    req_valid = 1'b1; req_wen = 1'b0; req_addr = addr;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; ARREADY = 1'b0;
    chk("rst_arvalid", 64'(ARVALID), 64'd1);
    chk("rst_araddr", 64'(ARADDR), 64'(addr));
    #2 resetn = 1'b0;
    #1 chk_reset_vals("rst_async");
    @(negedge clk);
    chk_reset_vals("rst_hold");
    resetn = 1'b1;
    last_rdata = '0;
    last_err = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    logic wen;
    resetn = 1'b0;
    req_valid = 1'b0; req_wen = 1'b0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
    axi_idle();
    last_rdata = '0;
    last_err = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset_vals("reset");
    resetn = 1'b1;
    @(negedge clk);

    run_tx(1'b0, 32'h1000_0008, '0, '0, 64'h1122_3344_5566_7788, 2'b00, 0, 0, 0, 0);
    run_tx(1'b1, 32'h8000_0010, 64'hDEAD_BEEF_0000_0001, 8'h0F, '0, 2'b00, 3, 0, 0, 0);
    run_tx(1'b1, 32'h0000_0100, 64'h0123_4567_89AB_CDEF, 8'hF0, '0, 2'b10, 1, 2, 1, 0);
    run_tx(1'b0, 32'h0000_0200, '0, '0, 64'hCAFE_F00D_1234_5678, 2'b11, 1, 0, 2, 0);
    run_tx(1'b0, 32'h0000_0300, '0, '0, 64'hA5A5_5A5A_0F0F_F0F0, 2'b00, 0, 0, 0, 5);
    run_tx(1'b1, 32'h0000_0400, 64'h5555_AAAA_5555_AAAA, 8'hFF, '0, 2'b00, 0, 3, 0, 2);
    spurious(3);
    reset_mid();
    run_tx(1'b0, 32'h0000_0500, '0, '0, 64'h0BAD_C0DE_0000_0042, 2'b00, 0, 0, 0, 0);

    for (int i = 0; i < 40; i++) begin
      wen = 1'($urandom);
      run_tx(wen, $urandom, {$urandom, $urandom}, DS'($urandom), {$urandom, $urandom},
             ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00,
             int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
             int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
